clock_divider_ctrl: RTL and testbench
=====================================

CLOCK_DIVIDER_CTRL -- requirements
Module: clock_divider_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, as the counter and register data width.
REQ-002 The block SHALL have parameter DEF_PERIOD, default 1250, as the PERIOD reset value.
REQ-003 The block SHALL have parameter DEF_HIGH, default 625, as the HIGH reset value.
REQ-004 Port clock SHALL be an input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 Port avs_address SHALL be an input, 3 bits: register select.
REQ-007 Ports avs_write and avs_read SHALL be inputs, 1 bit each: single-cycle access strobes.
REQ-008 Port avs_writedata SHALL be an input, CNT_W bits: write data.
REQ-009 Port avs_readdata SHALL be an output, CNT_W bits: registered read data.
REQ-010 Port out_clk SHALL be an output, 1 bit: the divided clock / pulse output.
REQ-011 Port period_tick SHALL be an output, 1 bit: one-cycle pulse at each period wrap.
REQ-012 Ports busy and irq SHALL be outputs, 1 bit each: busy = state not IDLE; irq = level interrupt.

Function
REQ-013 The register map SHALL be:
- 0 CTRL (RW): bit0 EN, bit1 BURST, bit2 IRQ_EN
- 1 PERIOD (RW)
- 2 HIGH (RW)
- 3 BURST_CNT (RW)
- 4 STATUS: bit0 RUN (RO), bit1 DONE (W1C)
- 5 COUNTER (RO, live count)
- 6-7: read 0, writes ignored
REQ-014 Read latency SHALL be exactly 1 cycle; avs_readdata SHALL hold its value between reads.
REQ-015 Register writes SHALL update shadow registers immediately; the active PERIOD/HIGH copies SHALL load only on entry to RUN and at each wrap, so a period is never altered mid-cycle.
REQ-016 The state machine SHALL have three states:
- IDLE: counter = 0, out_clk = 0
- RUN
- STOPPING
REQ-017 IDLE SHALL go to RUN in the cycle after EN is written 1, loading the active copies and the remaining-burst count from BURST_CNT.
REQ-018 In RUN, the counter SHALL increment by 1 per cycle, and out_clk SHALL be 1 while counter < active HIGH, else 0.
REQ-019 When counter == active PERIOD, the counter SHALL wrap to 0 on the next edge and period_tick SHALL pulse for that one cycle; a period is therefore PERIOD+1 cycles long.
REQ-020 A PERIOD value of 0 SHALL be treated as 1.
REQ-021 HIGH = 0 SHALL hold out_clk low; HIGH > PERIOD SHALL hold out_clk high.
REQ-022 Writing EN = 0 during RUN SHALL enter STOPPING; the current period SHALL complete, then the block SHALL go to IDLE at the wrap.
REQ-023 Writing EN = 1 during STOPPING SHALL return to RUN with no gap.
REQ-024 In BURST mode, remaining SHALL decrement at each wrap; at 1→0 the block SHALL go to IDLE, set DONE, and self-clear EN.
REQ-025 BURST = 1 with BURST_CNT = 0 SHALL go to IDLE one cycle after entry to RUN, set DONE, and produce no out_clk pulse.
REQ-026 irq SHALL equal DONE & IRQ_EN.
REQ-027 When a DONE set and a DONE W1C occur in the same cycle, the set SHALL win.
REQ-028 The counter SHALL be CNT_W bits and SHALL never overflow, because wrap occurs at PERIOD ≤ 2^CNT_W−1.

Reset
REQ-029 While reset = 0, the block SHALL asynchronously force:
- state IDLE; counter 0
- out_clk, period_tick, busy, irq, avs_readdata = 0
- CTRL = 0, DONE = 0, BURST_CNT = 0
- PERIOD = DEF_PERIOD, HIGH = DEF_HIGH
REQ-030 Reset asserted mid-period SHALL abort immediately with no completion of the current period.
REQ-031 Reset release SHALL take effect at the next clock edge, with the block in IDLE.

Verification
REQ-032 Defaults: write EN = 1 → out_clk high for 625 cycles, low for 626; period_tick every 1251 cycles; COUNTER read returns the live count.
REQ-033 PERIOD = 3, HIGH = 2 written while running → the current 1251-cycle period finishes unchanged, then the pattern is 1,1,0,0 repeating.
REQ-034 BURST = 1, BURST_CNT = 3, PERIOD = 9, HIGH = 5, IRQ_EN = 1 → exactly 3 pulses of 5 cycles, then IDLE, DONE = 1, irq = 1, CTRL.EN reads 0; W1C on DONE → irq = 0.
REQ-035 EN = 0 written at counter = 4 (PERIOD = 9) → block reaches IDLE 6 cycles later; EN = 1 rewritten at counter = 7 → no gap in the pattern.
REQ-036 Edge values:
- HIGH = 0 → out_clk constantly 0
- HIGH = 20, PERIOD = 9 → out_clk constantly 1
- PERIOD = 0 → 2-cycle period
- BURST_CNT = 0 in BURST mode → DONE with no pulses
REQ-037 Reset = 0 asserted mid-burst → all outputs 0 and registers at their defaults within the same cycle.

Source files
------------

// File: rtl/clock_divider_ctrl.sv
// Programmable clock divider / pulse generator with an Avalon-MM register file.
// Shadow PERIOD/HIGH registers are copied into active registers only at run entry and at each wrap.
module clock_divider_ctrl #(
    parameter int          CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = 1250,
    parameter int unsigned DEF_HIGH   = 625
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_write,
    input  logic             avs_read,
    input  logic [CNT_W-1:0] avs_writedata,
    output logic [CNT_W-1:0] avs_readdata,
    output logic             out_clk,
    output logic             period_tick,
    output logic             busy,
    output logic             irq
);

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] RST_HIGH   = CNT_W'(DEF_HIGH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             out_clk_q, out_clk_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] rdata_q, rdata_d;

    logic active, wrap, burst_end, en_d, load;

    always_comb begin
        ctrl_d      = ctrl_q;
        period_d    = period_q;
        high_d      = high_q;
        burst_cnt_d = burst_cnt_q;
        done_d      = done_q;
        if (avs_write) begin
            case (avs_address)
                3'd0:    ctrl_d      = avs_writedata[2:0];
                3'd1:    period_d    = avs_writedata;
                3'd2:    high_d      = avs_writedata;
                3'd3:    burst_cnt_d = avs_writedata;
                3'd4:    if (avs_writedata[1]) done_d = 1'b0;
                default: ;
            endcase
        end

        // A burst ends on the last wrap, or at once when started with zero pulses.
        active    = (state_q != S_IDLE);
        wrap      = active && (counter_q == act_period_q);
        burst_end = active && ctrl_q[1] &&
                    ((remaining_q == '0) || (wrap && (remaining_q == ONE)));
        if (burst_end) begin
            ctrl_d[0] = 1'b0;
            done_d    = 1'b1;
        end
        en_d = ctrl_d[0];

        state_d     = state_q;
        counter_d   = counter_q;
        remaining_d = remaining_q;
        load        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_d) begin
                    state_d     = S_RUN;
                    counter_d   = '0;
                    remaining_d = burst_cnt_d;
                    load        = 1'b1;
                end
            end
            default: begin
                if (burst_end) begin
                    state_d   = S_IDLE;
                    counter_d = '0;
                end else if (wrap) begin
                    state_d   = en_d ? S_RUN : S_IDLE;
                    counter_d = '0;
                    load      = 1'b1;
                    if (ctrl_q[1]) remaining_d = remaining_q - ONE;
                end else begin
                    state_d   = en_d ? S_RUN : S_STOP;
                    counter_d = counter_q + ONE;
                end
            end
        endcase

        act_period_d = act_period_q;
        act_high_d   = act_high_q;
        if (load) begin
            act_period_d = (period_d == '0) ? ONE : period_d;
            act_high_d   = high_d;
        end

        // Outputs are derived from next-state values so they line up with the registered counter.
        busy_d    = (state_d != S_IDLE);
        out_clk_d = busy_d && !(ctrl_d[1] && (remaining_d == '0)) && (counter_d < act_high_d);
        tick_d    = busy_d && (counter_d == act_period_d);
        irq_d     = done_d & ctrl_d[2];

        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            case (avs_address)
                3'd0:    rdata_d[2:0] = ctrl_q;
                3'd1:    rdata_d      = period_q;
                3'd2:    rdata_d      = high_q;
                3'd3:    rdata_d      = burst_cnt_q;
                3'd4:    rdata_d[1:0] = {done_q, active};
                3'd5:    rdata_d      = counter_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ctrl_q       <= '0;
            period_q     <= RST_PERIOD;
            high_q       <= RST_HIGH;
            burst_cnt_q  <= '0;
            done_q       <= 1'b0;
            act_period_q <= RST_PERIOD;
            act_high_q   <= RST_HIGH;
            remaining_q  <= '0;
            counter_q    <= '0;
            out_clk_q    <= 1'b0;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            period_q     <= period_d;
            high_q       <= high_d;
            burst_cnt_q  <= burst_cnt_d;
            done_q       <= done_d;
            act_period_q <= act_period_d;
            act_high_q   <= act_high_d;
            remaining_q  <= remaining_d;
            counter_q    <= counter_d;
            out_clk_q    <= out_clk_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign out_clk      = out_clk_q;
    assign period_tick  = tick_q;
    assign busy         = busy_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench for clock_divider_ctrl: register table, pattern table and hand-written
// sequences for defaults, live reprogramming, burst, stop/restart and async reset.
module tb_clock_divider_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        out_clk, period_tick, busy, irq;

    int n_chk  = 0;
    int n_fail = 0;

    clock_divider_ctrl dut (
        .clock(clock), .reset(reset),
        .avs_address(avs_address), .avs_write(avs_write), .avs_read(avs_read),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .out_clk(out_clk), .period_tick(period_tick), .busy(busy), .irq(irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [31:0] period;
        logic [31:0] high;
        int          len;
        logic [15:0] pat;
    } pat_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick_clk();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick_clk();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            tick_clk();
            n++;
        end
        chk1("wait_idle_busy", busy, 1'b0);
        chk1("idle_out_clk", out_clk, 1'b0);
    endtask

    initial begin
        reg_vec_t    rv[9];
        pat_vec_t    pv[7];
        logic [31:0] d;

        rv[0] = '{3'd1, 32'h0000_00AB, 32'h0000_00AB};
        rv[1] = '{3'd2, 32'h1234_5678, 32'h1234_5678};
        rv[2] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        rv[3] = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0006};
        rv[4] = '{3'd6, 32'h0000_DEAD, 32'h0000_0000};
        rv[5] = '{3'd7, 32'h0000_BEEF, 32'h0000_0000};
        rv[6] = '{3'd5, 32'h0000_0099, 32'h0000_0000};
        rv[7] = '{3'd4, 32'h0000_0001, 32'h0000_0000};
        rv[8] = '{3'd1, 32'h0000_0000, 32'h0000_0000};

        pv[0] = '{32'd3, 32'd2,  4,  16'b0011};
        pv[1] = '{32'd0, 32'd1,  2,  16'b01};
        pv[2] = '{32'd5, 32'd0,  6,  16'b000000};
        pv[3] = '{32'd9, 32'd20, 10, 16'b11_1111_1111};
        pv[4] = '{32'd4, 32'd4,  5,  16'b01111};
        pv[5] = '{32'd0, 32'd0,  2,  16'b00};
        pv[6] = '{32'd7, 32'd3,  8,  16'b0000_0111};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk1("rst_out_clk", out_clk, 1'b0);
        chk1("rst_tick", period_tick, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_irq", irq, 1'b0);
        chk("rst_readdata", avs_readdata, 32'd0);
        reset = 1'b1;
        tick_clk();
        rd(3'd0, d); chk("rst_ctrl", d, 32'd0);
        rd(3'd1, d); chk("rst_period", d, 32'd1250);
        rd(3'd2, d); chk("rst_high", d, 32'd625);
        rd(3'd3, d); chk("rst_burst_cnt", d, 32'd0);
        rd(3'd4, d); chk("rst_status", d, 32'd0);
        rd(3'd5, d); chk("rst_counter", d, 32'd0);

        // Defaults, live COUNTER read, then PERIOD=3/HIGH=2 written mid-period
        wr(3'd0, 32'd1);
        for (int i = 0; i < 1263; i++) begin
            logic eo, et;
            if (i < 1251) begin
                eo = (i < 625);
                et = (i == 1250);
            end else begin
                eo = (((i - 1251) % 4) < 2);
                et = (((i - 1251) % 4) == 3);
            end
            chk1("def_out_clk", out_clk, eo);
            chk1("def_tick", period_tick, et);
            chk1("def_busy", busy, 1'b1);
            if (i == 101 || i == 105) chk("counter_read", avs_readdata, 32'd100);
            avs_read      = (i == 100);
            avs_write     = (i == 200 || i == 201);
            avs_address   = (i == 100) ? 3'd5 : ((i == 200) ? 3'd1 : 3'd2);
            avs_writedata = (i == 200) ? 32'd3 : 32'd2;
            tick_clk();
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        wr(3'd0, 32'd0);
        wait_idle(20);

        // Register map table
        foreach (rv[k]) begin
            wr(rv[k].addr, rv[k].wdata);
            rd(rv[k].addr, d);
            chk($sformatf("reg_vec%0d", k), d, rv[k].exp);
            chk1("reg_vec_busy", busy, 1'b0);
        end
        wr(3'd0, 32'd0);

        // Burst of 3 with IRQ
        wr(3'd1, 32'd9);
        wr(3'd2, 32'd5);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'd7);
        for (int i = 0; i < 34; i++) begin
            chk1("burst_out_clk", out_clk, (i < 30) && ((i % 10) < 5));
            chk1("burst_tick", period_tick, (i < 30) && ((i % 10) == 9));
            chk1("burst_busy", busy, (i < 30));
            chk1("burst_irq", irq, (i >= 30));
            tick_clk();
        end
        rd(3'd0, d); chk("burst_ctrl_en_clear", d, 32'd6);
        rd(3'd4, d); chk("burst_status_done", d, 32'd2);
        wr(3'd4, 32'd2);
        chk1("w1c_irq", irq, 1'b0);
        rd(3'd4, d); chk("w1c_status", d, 32'd0);

        // Zero-length burst, with a W1C landing on the same edge that sets DONE
        wr(3'd3, 32'd0);
        wr(3'd0, 32'd7);
        chk1("bz_busy_entry", busy, 1'b1);
        chk1("bz_out_entry", out_clk, 1'b0);
        wr(3'd4, 32'd2);
        chk1("bz_busy_after", busy, 1'b0);
        chk1("bz_out_after", out_clk, 1'b0);
        chk1("bz_irq", irq, 1'b1);
        rd(3'd4, d); chk("bz_set_wins", d, 32'd2);
        rd(3'd0, d); chk("bz_ctrl", d, 32'd6);
        wr(3'd4, 32'd2);
        rd(3'd4, d); chk("bz_cleared", d, 32'd0);

        // EN=0 at counter 4 with PERIOD=9: idle 6 cycles later
        wr(3'd0, 32'd1);
        for (int i = 0; i < 15; i++) begin
            chk1("stop_busy", busy, (i < 10));
            chk1("stop_out_clk", out_clk, (i < 10) && ((i % 10) < 5));
            avs_write     = (i == 4);
            avs_address   = 3'd0;
            avs_writedata = 32'd0;
            tick_clk();
        end
        avs_write = 1'b0;

        // EN=0 at counter 4, EN=1 at counter 7: seamless
        wr(3'd0, 32'd1);
        for (int i = 0; i < 26; i++) begin
            chk1("resume_busy", busy, 1'b1);
            chk1("resume_out_clk", out_clk, ((i % 10) < 5));
            chk1("resume_tick", period_tick, ((i % 10) == 9));
            avs_write     = (i == 4 || i == 7);
            avs_address   = 3'd0;
            avs_writedata = (i == 7) ? 32'd1 : 32'd0;
            tick_clk();
        end
        avs_write = 1'b0;
        wr(3'd0, 32'd0);
        wait_idle(20);

        // Steady-state pattern table (edge values included)
        foreach (pv[k]) begin
            wr(3'd1, pv[k].period);
            wr(3'd2, pv[k].high);
            wr(3'd0, 32'd1);
            for (int i = 0; i < 2 * pv[k].len; i++) begin
                chk1($sformatf("pat%0d_out_clk", k), out_clk, pv[k].pat[i % pv[k].len]);
                chk1($sformatf("pat%0d_tick", k), period_tick, ((i % pv[k].len) == pv[k].len - 1));
                tick_clk();
            end
            wr(3'd0, 32'd0);
            wait_idle(40);
        end

        // Asynchronous reset mid-burst
        wr(3'd1, 32'd9);
        wr(3'd2, 32'd5);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'd7);
        tick_clk();
        tick_clk();
        rd(3'd1, d); chk("pre_rst_read", d, 32'd9);
        chk1("pre_rst_out_clk", out_clk, 1'b1);
        reset = 1'b0;
        #1;
        chk1("arst_out_clk", out_clk, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_tick", period_tick, 1'b0);
        chk1("arst_irq", irq, 1'b0);
        chk("arst_readdata", avs_readdata, 32'd0);
        tick_clk();
        tick_clk();
        chk1("arst_hold_busy", busy, 1'b0);
        reset = 1'b1;
        tick_clk();
        chk1("post_rst_busy", busy, 1'b0);
        rd(3'd0, d); chk("post_rst_ctrl", d, 32'd0);
        rd(3'd1, d); chk("post_rst_period", d, 32'd1250);
        rd(3'd2, d); chk("post_rst_high", d, 32'd625);
        rd(3'd3, d); chk("post_rst_burst_cnt", d, 32'd0);
        rd(3'd4, d); chk("post_rst_status", d, 32'd0);
        rd(3'd5, d); chk("post_rst_counter", d, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
